// File: rtl/bsc_rr_arbiter.sv
// Round-robin arbiter: N requesters share one resource, grant held until release, registered outputs.
// Optional forced release after HOLD_MAX cycles: define BSC_RR_ARBITER_HOLD_LIMIT_EN.
module bsc_rr_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 16,
  localparam int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          busy,
  output logic          timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic [IW-1:0] ptr, ptr_next, idx_next, scan_start, win_idx, owner_inc;
  logic [N-1:0]  gnt_next, cand;
  logic          busy_next, win_found;
  logic          natural_rel, forced, rel;

  if (N < 2 || N > 16) begin : g_bad_n
    $error("bsc_rr_arbiter: N must be in 2..16");
  end
  if (HOLD_MAX < 1) begin : g_bad_hold
    $error("bsc_rr_arbiter: HOLD_MAX must be >= 1");
  end

  // Only the owner's own done/req can end a grant.
  assign natural_rel = (state == BUSY) && (done[gnt_idx] || !req[gnt_idx]);
  assign rel         = natural_rel || forced;
  assign owner_inc   = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + IW'(1);

`ifdef BSC_RR_ARBITER_HOLD_LIMIT_EN
  localparam int CW = $clog2(HOLD_MAX+1);
  logic [CW-1:0] hold_cnt;

  // Fires in the last allowed BUSY cycle so the handover lands after exactly HOLD_MAX cycles.
  assign forced = (state == BUSY) && !natural_rel && (hold_cnt == CW'(HOLD_MAX-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= forced;
      if (state == IDLE || rel) hold_cnt <= '0;
      else                      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign forced  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin : next_logic
    int j;
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_next = state;
    gnt_next   = gnt;
    idx_next   = gnt_idx;
    busy_next  = busy;
    ptr_next   = ptr;
    scan_start = ptr;
    cand       = '0;
    win_found  = 1'b0;
    win_idx    = '0;

    if (state == IDLE) begin
      cand = req;
    end else if (rel) begin
      ptr_next   = owner_inc;
      scan_start = owner_inc;
      cand       = req & ~gnt;
    end

    for (int k = 0; k < N; k++) begin
      j = int'(scan_start) + k;
      if (j >= N) j = j - N;
      if (!win_found && cand[j]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end

    if (state == IDLE || rel) begin
      if (win_found) begin
        gnt_next   = {{(N-1){1'b0}}, 1'b1} << win_idx;
        idx_next   = win_idx;
        busy_next  = 1'b1;
        state_next = BUSY;
      end else begin
        gnt_next   = '0;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the same pre-edge values.
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      busy    <= 1'b0;
      ptr     <= '0;
    end else begin
      state   <= state_next;
      gnt     <= gnt_next;
      gnt_idx <= idx_next;
      busy    <= busy_next;
      ptr     <= ptr_next;
    end
  end

endmodule

// File: tb/tb_bsc_rr_arbiter.sv
// Self-checking bench for bsc_rr_arbiter: vector table, hold-limit sequence, random run vs reference model.
module tb_bsc_rr_arbiter;
  localparam int N        = 4;
  localparam int HOLD_MAX = 4;
`ifdef BSC_RR_ARBITER_HOLD_LIMIT_EN
  localparam bit HOLD_EN  = 1'b1;
`else
  localparam bit HOLD_EN  = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, done, gnt;
  logic [1:0]   gnt_idx;
  logic         busy, timeout;

  int errors = 0;
  int checks = 0;

  // Reference model: owner as an int (-1 = idle), pointer and held-cycle count.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_held  = 0;
  int   m_idx   = 0;
  logic m_timeout = 1'b0;

  always #5 clk = ~clk;

  bsc_rr_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] r;
    logic [N-1:0] d;
    logic [N-1:0] g;
    logic         b;
    logic [1:0]   idx;
  } vec_t;

  vec_t vt[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] d);
    logic [N-1:0] c;
    bit rel, frc, arb;
    int j;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_idx = 0; m_timeout = 1'b0;
      return;
    end
    rel = 0; frc = 0; arb = 0; c = '0;
    if (m_owner < 0) begin
      arb = 1; c = r;
    end else begin
      if (d[m_owner] || !r[m_owner]) rel = 1;
      else if (HOLD_EN && m_held >= HOLD_MAX) frc = 1;
      if (rel || frc) begin
        m_ptr = (m_owner + 1) % N;
        c = r;
        c[m_owner] = 1'b0;
        arb = 1;
      end else begin
        m_held++;
      end
    end
    m_timeout = frc;
    if (arb) begin
      m_owner = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (m_owner < 0 && c[j]) m_owner = j;
      end
      if (m_owner >= 0) begin
        m_held = 1;
        m_idx  = m_owner;
      end
    end
  endtask

  // Called at a falling edge: drive inputs, advance the model, sample at the next falling edge.
  task automatic cycle(input logic rst, input logic [N-1:0] r, input logic [N-1:0] d);
    logic [N-1:0] exp_g;
    reset = rst; req = r; done = d;
    model_step(rst, r, d);
    @(posedge clk);
    @(negedge clk);
    exp_g = (m_owner >= 0) ? N'(1) << m_owner : '0;
    check("model_gnt", 32'(gnt), 32'(exp_g));
    check("model_busy", 32'(busy), 32'(m_owner >= 0));
    check("model_timeout", 32'(timeout), 32'(m_timeout));
    if (m_owner >= 0 || rst) check("model_idx", 32'(gnt_idx), 32'(m_idx));
  endtask

  initial begin
    int first_change, first_to;
    logic [N-1:0] r, d;
    logic rst;

    // rst, req, done -> gnt, busy, gnt_idx after the edge
    vt[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vt[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vt[2]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vt[3]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0};
    vt[4]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0};
    vt[5]  = '{1'b0, 4'b1111, 4'b0001, 4'b0010, 1'b1, 2'd1};
    vt[6]  = '{1'b0, 4'b1111, 4'b0100, 4'b0010, 1'b1, 2'd1};
    vt[7]  = '{1'b0, 4'b1111, 4'b0010, 4'b0100, 1'b1, 2'd2};
    vt[8]  = '{1'b0, 4'b1111, 4'b0100, 4'b1000, 1'b1, 2'd3};
    vt[9]  = '{1'b0, 4'b0011, 4'b1000, 4'b0001, 1'b1, 2'd0};
    vt[10] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1};
    vt[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vt[12] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vt[13] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2};
    vt[14] = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vt[15] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2};
    vt[16] = '{1'b0, 4'b1010, 4'b0000, 4'b1000, 1'b1, 2'd3};
    vt[17] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0};

    reset = 1'b1; req = '0; done = '0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      cycle(vt[i].rst, vt[i].r, vt[i].d);
      check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(vt[i].g));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vt[i].b));
      check($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'd0);
      if (vt[i].b || vt[i].rst) check($sformatf("tbl%0d_idx", i), 32'(gnt_idx), 32'(vt[i].idx));
    end

    // Owner 0 never releases while requester 1 waits.
    cycle(1'b1, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0001, 4'b0000);
    first_change = -1;
    first_to     = -1;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, 4'b0011, 4'b0000);
      if (first_change < 0 && gnt !== 4'b0001) first_change = i;
      if (first_to < 0 && timeout === 1'b1) first_to = i;
    end
    if (HOLD_EN) begin
      check("hold_change_cycle", 32'(first_change), 32'd3);
      check("hold_timeout_cycle", 32'(first_to), 32'd3);
    end else begin
      check("hold_change_cycle", 32'(first_change), 32'hffff_ffff);
      check("hold_timeout_cycle", 32'(first_to), 32'hffff_ffff);
    end

    cycle(1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 600; i++) begin
      r   = N'($urandom) | N'($urandom);
      d   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      rst = ($urandom_range(0, 63) == 0);
      cycle(rst, r, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
